// File: rtl/note_sched_pkg.sv
// note_sched_pkg: shared types and constants for the note scheduler.
//   state_t       - scheduler mode: IDLE / REC / PLAY (2-bit encoding visible on state_o)
//   slot_t        - one recorded step: noise enable plus divider factor
//   SLOT_DIV_W    - divider width stored in a slot; note_scheduler's DIV_W must match it
//   DEF_TEMPO_DIV - clock cycles per playback step at 12 MHz (4 steps per second)
package note_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    localparam int SLOT_DIV_W    = 16;
    localparam int DEF_TEMPO_DIV = 3000000;

    typedef struct packed {
        logic                  noise;
        logic [SLOT_DIV_W-1:0] div;
    } slot_t;

endpackage

// File: rtl/note_scheduler_tempo_timer.sv
// tempo_timer: free-running step timer for sequencer playback.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - hold the count at zero (used whenever the sequencer is not playing)
//   tick  - one-cycle pulse while the count sits at TEMPO_DIV-1
module tempo_timer #(
    parameter int TEMPO_DIV = 3000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int TW = (TEMPO_DIV > 2) ? $clog2(TEMPO_DIV) : 1;
    localparam logic [TW-1:0] TERM = TW'(TEMPO_DIV - 1);

    logic [TW-1:0] count;

    // Counts 0..TEMPO_DIV-1 and wraps; clear forces a fresh start so the first
    // playback step always lasts a full tempo period.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == TERM) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

    assign tick = (count == TERM) && !clear;

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: arbitrates between live keypad notes and a small step
// sequencer, then applies an octave shift before driving the clock divider.
//   clk_i         - system clock (12 MHz)
//   rst_i         - synchronous active-high reset; also wipes the recorded pattern
//   live_div_i    - divider factor from the keypad decoder
//   live_noise_i  - noise enable from the keypad decoder
//   live_valid_i  - a key is currently held
//   rec_i         - record button level (debounced)
//   play_i        - play button level (debounced)
//   octave_up_i   - halve the divider (one octave up)
//   octave_down_i - double the divider (one octave down)
//   div_factor_o  - registered divider factor, 0 = mute
//   noise_en_o    - registered noise enable
//   step_o        - record slot (REC) or playback slot (PLAY/IDLE)
//   state_o       - 0 = IDLE, 1 = REC, 2 = PLAY
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int STEPS     = 8,
    parameter int TEMPO_DIV = DEF_TEMPO_DIV,
    parameter int DIV_W     = SLOT_DIV_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIV_W-1:0]         live_div_i,
    input  logic                     live_noise_i,
    input  logic                     live_valid_i,
    input  logic                     rec_i,
    input  logic                     play_i,
    input  logic                     octave_up_i,
    input  logic                     octave_down_i,
    output logic [DIV_W-1:0]         div_factor_o,
    output logic                     noise_en_o,
    output logic [$clog2(STEPS)-1:0] step_o,
    output logic [1:0]               state_o
);

    localparam int SW = $clog2(STEPS);
    // count needs one extra bit so it can hold STEPS itself (a full pattern)
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] FULL = CW'(STEPS);

    state_t          state_q, state_n;
    logic [CW-1:0]   count_q, count_n;
    logic [SW-1:0]   step_q, step_n;
    slot_t           slots [STEPS];

    logic            rec_q, play_q, valid_q;
    logic            rec_rise, play_rise, valid_rise;
    logic            wr_en;
    logic            tick;
    slot_t           rd_slot;
    logic [DIV_W-1:0] src_div;
    logic            src_noise;

    // Halving never reaches zero on a sounding note, since 0 would mean mute;
    // doubling saturates instead of wrapping to a higher pitch.
    function automatic logic [DIV_W-1:0] octave_shift(input logic [DIV_W-1:0] d,
                                                      input logic up,
                                                      input logic down);
        logic [DIV_W-1:0] r;
        r = d;
        if (d != '0) begin
            if (up && !down) begin
                r = d >> 1;
                if (r == '0) r = DIV_W'(1);
            end else if (down && !up) begin
                r = d[DIV_W-1] ? '1 : (d << 1);
            end
        end
        return r;
    endfunction

    assign rec_rise   = rec_i && !rec_q;
    assign play_rise  = play_i && !play_q;
    assign valid_rise = live_valid_i && !valid_q;

    // The timer only runs while playing; any other state holds it cleared so
    // entering PLAY always starts step 0 with a full tempo period.
    tempo_timer #(
        .TEMPO_DIV (TEMPO_DIV)
    ) u_tempo (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (state_q != S_PLAY),
        .tick  (tick)
    );

    // Mode transitions. rec is checked before play so a simultaneous press
    // of both buttons always favours recording. In REC the slot write is
    // evaluated first, so the auto-exit on a full pattern never loses the
    // last note.
    always_comb begin
        state_n = state_q;
        count_n = count_q;
        step_n  = step_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rec_rise) begin
                    state_n = S_REC;
                    count_n = '0;
                    step_n  = '0;
                end else if (play_rise && count_q != '0) begin
                    state_n = S_PLAY;
                    step_n  = '0;
                end
            end
            S_REC: begin
                if (valid_rise && count_q < FULL) begin
                    wr_en   = 1'b1;
                    count_n = count_q + CW'(1);
                end
                if (rec_rise) begin
                    state_n = S_IDLE;
                end else if (play_rise) begin
                    state_n = (count_n != '0) ? S_PLAY : S_IDLE;
                    step_n  = '0;
                end else if (count_n == FULL) begin
                    state_n = S_IDLE;
                end
            end
            S_PLAY: begin
                if (rec_rise) begin
                    state_n = S_REC;
                    count_n = '0;
                    step_n  = '0;
                end else if (play_rise) begin
                    state_n = S_IDLE;
                end else if (tick) begin
                    step_n = (CW'(step_q) == count_q - CW'(1)) ? '0 : step_q + SW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Source selection looks at the next state and step so the registered
    // outputs line up with state_o/step_o. A slot being written this very
    // cycle is forwarded so a REC->PLAY jump never plays a stale entry.
    always_comb begin
        if (wr_en && count_q[SW-1:0] == step_n) begin
            rd_slot = '{noise: live_noise_i, div: SLOT_DIV_W'(live_div_i)};
        end else begin
            rd_slot = slots[step_n];
        end
        src_div   = live_valid_i ? live_div_i : '0;
        src_noise = live_valid_i && live_noise_i;
        if (state_n == S_PLAY && !live_valid_i) begin
            src_div   = DIV_W'(rd_slot.div);
            src_noise = rd_slot.noise;
        end
    end

    // All state, pattern memory and outputs. Reset also clears the slots so
    // an aborted recording leaves nothing behind.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            step_q       <= '0;
            rec_q        <= 1'b0;
            play_q       <= 1'b0;
            valid_q      <= 1'b0;
            div_factor_o <= '0;
            noise_en_o   <= 1'b0;
            step_o       <= '0;
            state_o      <= 2'd0;
            for (int i = 0; i < STEPS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            step_q  <= step_n;
            rec_q   <= rec_i;
            play_q  <= play_i;
            valid_q <= live_valid_i;
            if (wr_en) begin
                slots[count_q[SW-1:0]] <= '{noise: live_noise_i, div: SLOT_DIV_W'(live_div_i)};
            end
            div_factor_o <= octave_shift(src_div, octave_up_i, octave_down_i);
            noise_en_o   <= src_noise;
            step_o       <= (state_n == S_REC) ? count_n[SW-1:0] : step_n;
            state_o      <= state_n;
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: self-checking bench for note_scheduler with a short
// tempo (4 cycles per step) and 8 slots. Each applied vector carries its
// expected registered outputs, which are queued and checked one cycle later.
module tb_note_scheduler;

    localparam int STEPS = 8;
    localparam int TD    = 4;
    localparam int DW    = 16;

    typedef struct {
        logic        rst;
        logic [15:0] vd;
        logic        vn;
        logic        vv;
        logic        rec;
        logic        play;
        logic        up;
        logic        dn;
        logic [15:0] ediv;
        logic        en;
        logic [1:0]  est;
        int          estep;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] live_div_i;
    logic        live_noise_i;
    logic        live_valid_i;
    logic        rec_i;
    logic        play_i;
    logic        octave_up_i;
    logic        octave_down_i;
    logic [15:0] div_factor_o;
    logic        noise_en_o;
    logic [2:0]  step_o;
    logic [1:0]  state_o;

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t tbl[$];
    string phase = "init";

    always #5 clk = ~clk;

    note_scheduler #(
        .STEPS     (STEPS),
        .TEMPO_DIV (TD),
        .DIV_W     (DW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .live_div_i    (live_div_i),
        .live_noise_i  (live_noise_i),
        .live_valid_i  (live_valid_i),
        .rec_i         (rec_i),
        .play_i        (play_i),
        .octave_up_i   (octave_up_i),
        .octave_down_i (octave_down_i),
        .div_factor_o  (div_factor_o),
        .noise_en_o    (noise_en_o),
        .step_o        (step_o),
        .state_o       (state_o)
    );

    function automatic vec_t v(input logic [15:0] vd, input logic vn, input logic vv,
                               input logic rec, input logic play, input logic up,
                               input logic dn, input logic [15:0] ediv, input logic en,
                               input logic [1:0] est, input int estep);
        vec_t r;
        r.rst = 1'b0; r.vd = vd; r.vn = vn; r.vv = vv; r.rec = rec; r.play = play;
        r.up = up; r.dn = dn; r.ediv = ediv; r.en = en; r.est = est; r.estep = estep;
        return r;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, nm, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s/scoreboard: no expected entry queued", phase);
            return;
        end
        e = sb.pop_front();
        cmp("div", 32'(div_factor_o), 32'(e.ediv));
        cmp("noise", 32'(noise_en_o), 32'(e.en));
        cmp("state", 32'(state_o), 32'(e.est));
        if (e.estep >= 0) cmp("step", 32'(step_o), 32'(e.estep));
    endtask

    task automatic applyStimulus(input vec_t x);
        rst_i         = x.rst;
        live_div_i    = x.vd;
        live_noise_i  = x.vn;
        live_valid_i  = x.vv;
        rec_i         = x.rec;
        play_i        = x.play;
        octave_up_i   = x.up;
        octave_down_i = x.dn;
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t x;
        logic [15:0] pat [3];
        logic        patn [3];
        logic [15:0] d;
        int s;
        pat[0] = 16'h0200; pat[1] = 16'h0300; pat[2] = 16'h0400;
        patn[0] = 1'b0;    patn[1] = 1'b1;    patn[2] = 1'b0;

        // Reset
        phase = "reset";
        for (int i = 0; i < 2; i++) begin
            x = v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, 0);
            x.rst = 1'b1;
            applyStimulus(x);
        end

        // Live path and octave shift in IDLE, table-driven
        phase = "live_octave";
        tbl.push_back(v(16'h0100, 1, 1, 0, 0, 0, 0, 16'h0100, 1, 2'd0, 0));
        tbl.push_back(v(16'h0100, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0));
        tbl.push_back(v(16'h0100, 0, 1, 0, 0, 1, 0, 16'h0080, 0, 2'd0, 0));
        tbl.push_back(v(16'h0001, 0, 1, 0, 0, 1, 0, 16'h0001, 0, 2'd0, 0));
        tbl.push_back(v(16'h0003, 0, 1, 0, 0, 1, 0, 16'h0001, 0, 2'd0, 0));
        tbl.push_back(v(16'hC000, 0, 1, 0, 0, 0, 1, 16'hFFFF, 0, 2'd0, 0));
        tbl.push_back(v(16'h4000, 0, 1, 0, 0, 0, 1, 16'h8000, 0, 2'd0, 0));
        tbl.push_back(v(16'h0100, 0, 1, 0, 0, 1, 1, 16'h0100, 0, 2'd0, 0));
        tbl.push_back(v(16'h0000, 1, 1, 0, 0, 0, 1, 16'h0000, 1, 2'd0, 0));
        tbl.push_back(v(16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 0, 2'd0, 0));
        tbl.push_back(v(16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 2'd0, 0));
        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Record three notes
        phase = "record3";
        applyStimulus(v(16'h0, 0, 0, 1, 0, 0, 0, 16'h0, 0, 2'd1, 0));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd1, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(v(pat[i], patn[i], 1, 0, 0, 0, 0, pat[i], patn[i], 2'd1, i + 1));
            applyStimulus(v(pat[i], patn[i], 0, 0, 0, 0, 0, 16'h0, 0, 2'd1, i + 1));
        end
        applyStimulus(v(16'h0, 0, 0, 1, 0, 0, 0, 16'h0, 0, 2'd0, -1));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, -1));

        // Playback with a live preemption window in the middle
        phase = "play3";
        for (int k = 0; k < 28; k++) begin
            s = (k / TD) % 3;
            if (k >= 16 && k < 22)
                applyStimulus(v(16'h0050, 0, 1, 0, k == 0, 0, 0, 16'h0050, 0, 2'd2, s));
            else
                applyStimulus(v(16'h0050, 0, 0, 0, k == 0, 0, 0, pat[s], patn[s], 2'd2, s));
        end

        // Play toggling, then rec and play together
        phase = "toggle";
        applyStimulus(v(16'h0, 0, 0, 0, 1, 0, 0, 16'h0, 0, 2'd0, -1));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, -1));
        applyStimulus(v(16'h0, 0, 0, 0, 1, 0, 0, 16'h0200, 0, 2'd2, 0));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0200, 0, 2'd2, 0));
        applyStimulus(v(16'h0, 0, 0, 0, 1, 0, 0, 16'h0, 0, 2'd0, -1));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, -1));
        applyStimulus(v(16'h0, 0, 0, 1, 1, 0, 0, 16'h0, 0, 2'd1, 0));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd1, 0));

        // Fill all eight slots; the last press drops back to IDLE
        phase = "record8";
        for (int i = 0; i < STEPS; i++) begin
            d = 16'(16 * (i + 1));
            applyStimulus(v(d, 0, 1, 0, 0, 0, 0, d, 0, (i < STEPS - 1) ? 2'd1 : 2'd0,
                            (i < STEPS - 1) ? i + 1 : -1));
            applyStimulus(v(d, 0, 0, 0, 0, 0, 0, 16'h0, 0, (i < STEPS - 1) ? 2'd1 : 2'd0,
                            (i < STEPS - 1) ? i + 1 : -1));
        end
        applyStimulus(v(16'h0999, 0, 1, 0, 0, 0, 0, 16'h0999, 0, 2'd0, -1));
        applyStimulus(v(16'h0999, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, -1));

        // Play all eight and wrap to slot 0
        phase = "play8";
        for (int k = 0; k < 36; k++) begin
            s = (k / TD) % STEPS;
            applyStimulus(v(16'h0, 0, 0, 0, k == 0, 0, 0, 16'(16 * (s + 1)), 0, 2'd2, s));
        end

        // Reset mid-PLAY wipes the pattern
        phase = "reset_play";
        x = v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, 0);
        x.rst = 1'b1;
        applyStimulus(x);
        applyStimulus(v(16'h0, 0, 0, 0, 1, 0, 0, 16'h0, 0, 2'd0, 0));
        applyStimulus(v(16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 2'd0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
